pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle MIPS processor. It owns the PC register and selects the next PC for sequential flow, branches, J/JAL, JR and exception entry, preserving the supervisor bit (PC MSB). An optional return-address stack (RAS) checks JR $ra targets against the link history and flags mismatches. It sits between the control unit/regfile and instruction memory.

---
 rtl/pc_unit.sv | 199 +++++++++++++++++++
 tb/tb_pc_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the single-cycle MIPS core.
//
// Owns the PC register and picks the next PC for sequential flow, taken
// branches, J/JAL, JR and exception entry. Bit WIDTH-1 of the PC is the
// supervisor bit. It is carried through every target except two cases. A JR
// may drop from supervisor to user mode but never climbs back. The
// exception vector supplies its own supervisor bit.
//
// Optional feature (macro PC_UNIT_RAS_EN):
//   defined   : a return-address stack records JAL/JALR link addresses, and
//               each JR $ra target is checked against the stack top. Any
//               disagreement is flagged on ras_mispredict for one cycle.
//   undefined : no stack is built. link/ret are ignored and the RAS
//               outputs are tied to their empty-stack constants.
//
// Handshake: none. This is a free-running datapath block. A cycle with
//   stall=1 freezes every register (PC, RAS, mispredict flag). All other
//   cycles load on the rising edge.
//
// Ports:
//   clk            in   clock, rising-edge active
//   reset          in   asynchronous, active-high reset
//   stall          in   hold all state this cycle
//   Jump[1:0]      in   00 seq/branch, 01 J/JAL, 10 JR, 11 exception
//   taken          in   branch condition (only with Jump=00)
//   offset[25:0]   in   J/JAL instruction index
//   branchAddr     in   word-aligned branch target
//   radata         in   register-file read port 1 (JR target)
//   link           in   push pcp4 onto the RAS
//   ret            in   pop the RAS and check the JR target
//   pc             out  current PC
//   pcp4           out  pc + 4 (wraps modulo 2^WIDTH)
//   ras_top        out  top RAS entry, 0 when empty
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
//   ras_mispredict out  last pop disagreed with the JR target
// ---------------------------------------------------------------------------
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter int               RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC  = {1'b1, {(WIDTH-1){1'b0}}},
   parameter logic [WIDTH-1:0] EXC_VEC   = {1'b1, {(WIDTH-1){1'b0}}} | WIDTH'(32'h180)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [1:0]       Jump,
   input  logic             taken,
   input  logic [25:0]      offset,
   input  logic [WIDTH-1:0] branchAddr,
   input  logic [WIDTH-1:0] radata,
   input  logic             link,
   input  logic             ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pcp4,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_mispredict
);

   localparam logic [1:0] JMP_SEQ = 2'b00;
   localparam logic [1:0] JMP_IMM = 2'b01;
   localparam logic [1:0] JMP_REG = 2'b10;
   localparam logic [1:0] JMP_EXC = 2'b11;

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pcp4;
   logic [WIDTH-1:0] w_jtarget;
   logic [WIDTH-1:0] w_next_pc;
   logic             w_s;

   assign w_s    = r_pc[WIDTH-1];
   assign w_pcp4 = r_pc + WIDTH'(4);

   // J/JAL target: the top nibble comes from pcp4, the 26-bit index is
   // shifted into word position, and the rest of the PC is zero-filled.
   assign w_jtarget = {w_pcp4[WIDTH-1:28], offset, 2'b00};

   // ------------------------------------------------------------------------
   // Next-PC selection
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_pc = w_pcp4;
      case (Jump)
         JMP_SEQ: begin
            if (taken) w_next_pc = {w_s, branchAddr[WIDTH-2:0]};
            else       w_next_pc = w_pcp4;
         end
         JMP_IMM: w_next_pc = {w_s, w_jtarget[WIDTH-2:0]};
         JMP_REG: begin
            // Supervisor may return to user mode. User mode keeps s=0 even
            // when the register asks for supervisor.
            if (w_s && !radata[WIDTH-1]) w_next_pc = radata;
            else                         w_next_pc = {w_s, radata[WIDTH-2:0]};
         end
         JMP_EXC: w_next_pc = EXC_VEC;
         default: w_next_pc = w_pcp4;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_pc <= RESET_PC;
      else if (!stall) r_pc <= w_next_pc;
   end

   assign pc   = r_pc;
   assign pcp4 = w_pcp4;

`ifdef PC_UNIT_RAS_EN
   // ------------------------------------------------------------------------
   // Return-address stack: circular buffer. r_ptr points at the top entry
   // and r_cnt counts the valid entries (0..RAS_DEPTH). A push when full
   // wraps onto the oldest entry. The count stays saturated.
   // ------------------------------------------------------------------------
   localparam int PW = $clog2(RAS_DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0]    r_ptr;
   logic [PW:0]      r_cnt;
   logic             r_mis;
   logic [WIDTH-1:0] w_top;
   logic [PW-1:0]    w_ptr_inc;
   logic [PW-1:0]    w_ptr_dec;
   logic             w_ras_act;
   logic             w_cnt_zero;
   logic             w_top_miss;
   logic             w_unused;

   assign w_ptr_inc  = r_ptr + 1'b1;
   assign w_ptr_dec  = r_ptr - 1'b1;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_top      = w_cnt_zero ? '0 : r_ras[r_ptr];
   assign w_top_miss = (w_top != w_next_pc);
   // The exception path ignores link/ret entirely.
   assign w_ras_act  = !stall && (Jump != JMP_EXC);
   assign w_unused   = branchAddr[WIDTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
         r_cnt <= '0;
         r_mis <= 1'b0;
      end else if (!stall) begin
         r_mis <= 1'b0;
         if (w_ras_act) begin
            case ({link, ret})
               2'b10: begin
                  r_ptr <= w_ptr_inc;
                  if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
               end
               2'b01: begin
                  if (w_cnt_zero) begin
                     // Popping an empty stack predicts nothing, so it is
                     // always a miss. State stays put.
                     r_mis <= 1'b1;
                  end else begin
                     r_mis <= w_top_miss;
                     r_ptr <= w_ptr_dec;
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               2'b11: begin
                  // Replace-top: the pointer stays and the count holds,
                  // except that an empty stack becomes one entry.
                  r_mis <= w_cnt_zero ? 1'b1 : w_top_miss;
                  if (w_cnt_zero) r_cnt <= (PW+1)'(1);
               end
               default: ;
            endcase
         end
      end
   end

   // Entry storage needs no reset: the count masks stale contents.
   always_ff @(posedge clk) begin
      if (w_ras_act) begin
         if (link && !ret)     r_ras[w_ptr_inc] <= w_pcp4;
         else if (link && ret) r_ras[r_ptr]     <= w_pcp4;
      end
   end

   assign ras_top        = w_top;
   assign ras_empty      = w_cnt_zero;
   assign ras_full       = (r_cnt == CNT_FULL);
   assign ras_mispredict = r_mis;
`else
   logic w_unused;

   assign w_unused       = &{1'b0, link, ret, branchAddr[WIDTH-1]};
   assign ras_top        = '0;
   assign ras_empty      = 1'b1;
   assign ras_full       = 1'b0;
   assign ras_mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- directed-vector bench for pc_unit (WIDTH=32, RAS_DEPTH=4).
// Expected values are hand-computed constants. The RAS section follows
// the PC_UNIT_RAS_EN build option.
// ---------------------------------------------------------------------------
module tb_pc_unit;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         stall;
   logic [1:0]   Jump;
   logic         taken;
   logic [25:0]  offset;
   logic [W-1:0] branchAddr;
   logic [W-1:0] radata;
   logic         link;
   logic         ret;
   logic [W-1:0] pc;
   logic [W-1:0] pcp4;
   logic [W-1:0] ras_top;
   logic         ras_empty;
   logic         ras_full;
   logic         ras_mispredict;

   int n_checks;
   int n_fail;

   pc_unit #(.WIDTH(W), .RAS_DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .Jump           (Jump),
      .taken          (taken),
      .offset         (offset),
      .branchAddr     (branchAddr),
      .radata         (radata),
      .link           (link),
      .ret            (ret),
      .pc             (pc),
      .pcp4           (pcp4),
      .ras_top        (ras_top),
      .ras_empty      (ras_empty),
      .ras_full       (ras_full),
      .ras_mispredict (ras_mispredict)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      stall = 1'b0; Jump = 2'b00; taken = 1'b0; offset = '0;
      branchAddr = '0; radata = '0; link = 1'b0; ret = 1'b0;
   endtask

   // One clock: inputs already set, sample 1ns after the edge, then idle.
   task automatic step();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic branch_to(input logic [W-1:0] a);
      Jump = 2'b00; taken = 1'b1; branchAddr = a;
      step();
   endtask

   task automatic push();
      link = 1'b1;
      step();
   endtask

   task automatic pop(input logic [W-1:0] target);
      ret = 1'b1; Jump = 2'b10; radata = target;
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle_inputs();
      #2;
      check("reset_pc_async", pc, 32'h8000_0000);
      do_reset();
      check("reset_pc", pc, 32'h8000_0000);
      check("reset_pcp4", pcp4, 32'h8000_0004);
      check("reset_empty", W'(ras_empty), 1);
      check("reset_full", W'(ras_full), 0);
      check("reset_top", ras_top, 0);
      check("reset_mis", W'(ras_mispredict), 0);

      // sequential flow
      step(); check("seq1", pc, 32'h8000_0004);
      step(); check("seq2", pc, 32'h8000_0008);
      step(); check("seq3", pc, 32'h8000_000C);

      // JR supervisor -> user
      do_reset();
      Jump = 2'b10; radata = 32'h0040_0010; step();
      check("jr_drop_user", pc, 32'h0040_0010);
      Jump = 2'b10; radata = 32'h0040_0000; step();
      check("jr_user", pc, 32'h0040_0000);
      // JR user mode cannot escalate
      Jump = 2'b10; radata = 32'h8000_1000; step();
      check("jr_no_escalate", pc, 32'h0000_1000);
      // branch in user mode keeps s=0
      branch_to(32'h8000_2000);
      check("br_user", pc, 32'h0000_2000);
      // exception entry
      Jump = 2'b11; link = 1'b1; ret = 1'b1; step();
      check("exc_vec", pc, 32'h8000_0180);
      // branch in supervisor keeps s=1
      branch_to(32'h0040_0000);
      check("br_super", pc, 32'h8040_0000);
      // J keeps superbit, top nibble from pcp4
      Jump = 2'b01; offset = 26'h000_0100; step();
      check("j_imm", pc, 32'h8000_0400);
      // stall holds pc
      stall = 1'b1; Jump = 2'b00; taken = 1'b1; branchAddr = 32'h0000_1234; step();
      check("stall_pc", pc, 32'h8000_0400);
      // pcp4 wrap
      branch_to(32'h7FFF_FFFC);
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_pcp4", pcp4, 32'h0000_0000);
      step();
      check("wrap_seq", pc, 32'h0000_0000);

`ifdef PC_UNIT_RAS_EN
      // six pushes A..F = 0x80000004..0x80000018, depth 4
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         push();
         if (i == 4) check("full_after4", W'(ras_full), 1);
         if (i == 3) check("notfull_after3", W'(ras_full), 0);
      end
      check("top_F", ras_top, 32'h8000_0018);
      // four pops F, E, D, C
      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] e;
         e = 32'h8000_0018 - W'(4 * i);
         check($sformatf("pop%0d_top", i), ras_top, e);
         pop(e);
         check($sformatf("pop%0d_mis", i), W'(ras_mispredict), 0);
         check($sformatf("pop%0d_pc", i), pc, e);
      end
      check("empty_after4", W'(ras_empty), 1);
      check("top_empty", ras_top, 0);
      // fifth pop on empty
      pop(32'h8000_0040);
      check("pop5_mis", W'(ras_mispredict), 1);
      check("pop5_empty", W'(ras_empty), 1);
      step();
      check("mis_clear", W'(ras_mispredict), 0);

      // push 0x80000010 then mismatching ret
      branch_to(32'h0000_000C);
      push();
      check("push10_top", ras_top, 32'h8000_0010);
      pop(32'h8000_0020);
      check("miss_mis", W'(ras_mispredict), 1);
      check("miss_pc", pc, 32'h8000_0020);
      check("miss_empty", W'(ras_empty), 1);
      step();
      check("miss_one_cycle", W'(ras_mispredict), 0);

      // stall across a pop and a push: nothing moves
      push();
      check("stall_pre_top", ras_top, 32'h8000_0028);
      stall = 1'b1; ret = 1'b1; Jump = 2'b10; radata = 32'h8000_0100; step();
      check("stall_top", ras_top, 32'h8000_0028);
      check("stall_pc2", pc, 32'h8000_0028);
      check("stall_mis", W'(ras_mispredict), 0);
      stall = 1'b1; link = 1'b1; step();
      check("stall_push_top", ras_top, 32'h8000_0028);

      // simultaneous link+ret replaces the top
      do_reset();
      push(); push();
      check("two_top", ras_top, 32'h8000_0008);
      link = 1'b1; pop(32'h8000_0008);
      check("lr_mis", W'(ras_mispredict), 0);
      check("lr_top", ras_top, 32'h8000_000C);
      pop(32'h8000_000C);
      check("lr_pop_mis", W'(ras_mispredict), 0);
      check("lr_pop_top", ras_top, 32'h8000_0004);
      push(); push();
      check("three_top", ras_top, 32'h8000_0014);

      // mid-stream async reset with 3 entries
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_pc", pc, 32'h8000_0000);
      check("midrst_empty", W'(ras_empty), 1);
      check("midrst_top", ras_top, 0);
      @(negedge clk);
      reset = 1'b0;
`else
      // RAS absent: outputs are constants whatever link/ret do
      do_reset();
      push(); push();
      check("noras_top", ras_top, 0);
      check("noras_empty", W'(ras_empty), 1);
      pop(32'h8000_0100);
      check("noras_mis", W'(ras_mispredict), 0);
      check("noras_full", W'(ras_full), 0);
      check("noras_pc", pc, 32'h8000_0100);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_pc", pc, 32'h8000_0000);
      @(negedge clk);
      reset = 1'b0;
`endif
      // first edge after reset loads normally
      #1;
      step();
      check("post_rst_seq", pc, 32'h8000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
